wb_cmd_master: RTL

- Wishbone initiator that turns a simple valid/ready command stream into single Wishbone transactions.
- Returns one response per command: read data plus error and timeout status.
- Sits between the CPU, debug or DMA command logic and Wishbone responders such as the on-chip RAM.
- One transaction outstanding at a time. Supports classic (stb held until ack) and pipelined (stb dropped after accept) signalling.

---
 rtl/wb_cmd_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone initiator: converts a valid/ready command stream into single Wishbone
// transactions, one outstanding at a time, and returns one response per command.
module wb_cmd_master #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int CLASSIC        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [WB_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [WB_DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic                       cmd_we_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [WB_DATA_WIDTH-1:0]   rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       rsp_timeout_o,
    output logic [WB_ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
    output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                       wb_we_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
    input  logic                       wb_ack_i,
    input  logic                       wb_err_i,
    input  logic                       wb_stall_i
);

    localparam int SEL_W = WB_DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                     r_state;
    logic                       r_cmd_ready;
    logic                       r_cyc;
    logic                       r_stb;
    logic                       r_we;
    logic [WB_ADDR_WIDTH-1:0]   r_addr;
    logic [WB_DATA_WIDTH-1:0]   r_wdata;
    logic [SEL_W-1:0]           r_sel;
    logic                       r_rsp_valid;
    logic [WB_DATA_WIDTH-1:0]   r_rsp_data;
    logic                       r_rsp_err;
    logic                       r_rsp_timeout;
    logic [CNT_W-1:0]           r_cnt;

    logic [CNT_W-1:0]           w_cnt_next;
    logic                       w_timeout;

    // The counter value after this cycle equals the number of cycles spent in REQ/WAIT.
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    // NOTE: all state updates use <= so every register samples pre-edge values of its peers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_sel         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && cmd_valid_i) begin
                        r_addr      <= cmd_addr_i;
                        r_wdata     <= cmd_data_i;
                        r_sel       <= cmd_sel_i;
                        r_we        <= cmd_we_i;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_REQ;
                    end else begin
                        // Ready rises one cycle after returning from RESP, never overlapping it.
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_REQ, S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (wb_err_i || wb_ack_i || w_timeout) begin
                        r_cyc         <= 1'b0;
                        r_stb         <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= wb_err_i;
                        r_rsp_timeout <= !wb_err_i && !wb_ack_i;
                        r_rsp_data    <= (!wb_err_i && wb_ack_i && !r_we) ? wb_data_i : '0;
                        r_state       <= S_RESP;
                    end else if ((CLASSIC == 0) && (r_state == S_REQ) && !wb_stall_i) begin
                        r_stb   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_data    <= '0;
                        r_state       <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign wb_addr_o     = r_addr;
    assign wb_data_o     = r_wdata;
    assign wb_sel_o      = r_sel;
    assign wb_we_o       = r_we;
    assign wb_cyc_o      = r_cyc;
    assign wb_stb_o      = r_stb;

endmodule
